// File: rtl/arb_pkg.sv
// Shared types and the round-robin search for req_round_robin_arbiter.
// The search is sized for the largest supported requester count (8).
package arb_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int MAX_REQ       = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of req[n-1:0], searching upward from last+1 with wrap.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         last,
                                       input int                 n);
    rr_pick_t   pick;
    logic [3:0] pos;
    pick = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      pos = {1'b0, last} + 4'(k);
      if (pos >= 4'(n)) pos = pos - 4'(n);
      if (k <= n && !pick.found && req[pos[2:0]]) begin
        pick.found = 1'b1;
        pick.idx   = pos[2:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/level_edge_detect.sv
// Per-requester level-to-pulse stage: optional counter debounce (REQ_DEBOUNCE_EN)
// followed by a rising-edge detector.
module level_edge_detect #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic lvl_i,
  output logic rise_o
);

  logic level;
  logic prev_q;

`ifdef REQ_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          filt_q;
  logic [CW-1:0] cnt_q;

  // Filtered level flips only after DB_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else if (lvl_i != filt_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        filt_q <= lvl_i;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign level = filt_q;
`else
  assign level = lvl_i;
`endif

  // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prev_q <= 1'b0;
    else       prev_q <= level;
  end

  assign rise_o = level & ~prev_q;

endmodule

// File: rtl/req_round_robin_arbiter.sv
// Round-robin arbiter: rising request edges latch as pending, an IDLE/BUSY FSM
// grants one at a time until res_done. REQ_DEBOUNCE_EN adds input debounce.
module req_round_robin_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEFAULT,
  parameter int DB_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req_lvl,
  input  logic                     res_done,
  output logic [N_REQ-1:0]         grant,
  output logic                     grant_valid,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [N_REQ-1:0]         pending
);

  localparam int IDW = $clog2(N_REQ);

  arb_state_e          state_q;
  logic [N_REQ-1:0]    rise;
  logic [N_REQ-1:0]    pending_q, pending_d;
  logic [N_REQ-1:0]    grant_q;
  logic                grant_valid_q;
  logic [IDW-1:0]      grant_id_q;
  logic [IDW-1:0]      last_q;
  logic [MAX_REQ-1:0]  req_ext;
  rr_pick_t            pick;
  logic [N_REQ-1:0]    pick_onehot;
  logic [N_REQ-1:0]    clr;

  for (genvar i = 0; i < N_REQ; i++) begin : g_edge
    level_edge_detect #(.DB_CYCLES(DB_CYCLES)) u_edge (
      .clk    (clk),
      .rstn   (rstn),
      .lvl_i  (req_lvl[i]),
      .rise_o (rise[i])
    );
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = pending_q;
    pick                 = rr_pick(req_ext, 3'(last_q), N_REQ);
    pick_onehot          = N_REQ'(1) << pick.idx;
    clr                  = (state_q == IDLE && pick.found) ? pick_onehot : '0;
    // Set after clear: a rise on the edge of its own grant is kept.
    pending_d            = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_q        <= IDW'(N_REQ - 1);
    end else begin
      case (state_q)
        IDLE: if (pick.found) begin
          state_q       <= BUSY;
          grant_q       <= pick_onehot;
          grant_valid_q <= 1'b1;
          grant_id_q    <= pick.idx[IDW-1:0];
          last_q        <= pick.idx[IDW-1:0];
        end
        BUSY: if (res_done) begin
          state_q       <= IDLE;
          grant_q       <= '0;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign pending     = pending_q;

endmodule
